// File: rtl/online_arith_pkg.sv
// Shared types, width helpers and digit utilities for the online arithmetic blocks.
//   digit_width()    : bits of one two's-complement signed digit for radix 2^k
//   residual_width() : bits of the online residual W
//   omst_state_t     : control states of the streaming online multiplier
//   SELM_*           : shape of the selection estimate used for output digits
//   digit_saturate() : folds the unused code -R onto -(R-1)
package online_arith_pkg;

    // Widest digit the helpers below handle.
    localparam int unsigned DIGIT_MAX_W = 8;

    // Number of fractional radix digits kept in the selection estimate.
    localparam int unsigned SELM_FRAC_DIGITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_LAST_OUT
    } omst_state_t;

    function automatic int unsigned digit_width(input int unsigned k);
        return k + 1;
    endfunction

    function automatic int unsigned residual_width(input int unsigned k,
                                                   input int unsigned max_digits,
                                                   input int unsigned delta);
        return (k + 1) * (max_digits + delta + 1);
    endfunction

    // Clamp a signed digit into [-(2^k-1), 2^k-1].
    function automatic logic signed [DIGIT_MAX_W-1:0] digit_saturate(
        input logic signed [DIGIT_MAX_W-1:0] d,
        input int unsigned                   k
    );
        logic signed [DIGIT_MAX_W-1:0] lim;
        lim = DIGIT_MAX_W'((1 << k) - 1);
        if (d > lim) begin
            return lim;
        end
        if (d < -lim) begin
            return -lim;
        end
        return d;
    endfunction

endpackage

// File: rtl/online_mult_step.sv
// One combinational online-multiplication iteration.
//   x_prev     : X_{j-1}, two's complement fraction with K*MAX_DIGITS fractional bits
//   y_cur      : Y_j (already includes this iteration's y digit), same format
//   x_d, y_d   : this iteration's operand digits (zero while draining)
//   w          : residual W, K*(MAX_DIGITS+DELTA) fractional bits
//   force_zero : suppress digit selection (first DELTA iterations)
//   p          : selected product digit
//   w_next     : updated residual V - p
module online_mult_step
    import online_arith_pkg::*;
#(
    parameter int unsigned K          = 2,
    parameter int unsigned DIGIT_BITS = digit_width(K),
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned DELTA      = 2
) (
    input  logic signed [DIGIT_BITS*MAX_DIGITS-1:0]               x_prev,
    input  logic signed [DIGIT_BITS*MAX_DIGITS-1:0]               y_cur,
    input  logic signed [DIGIT_BITS-1:0]                          x_d,
    input  logic signed [DIGIT_BITS-1:0]                          y_d,
    input  logic signed [residual_width(K, MAX_DIGITS, DELTA)-1:0] w,
    input  logic                                                  force_zero,
    output logic signed [DIGIT_BITS-1:0]                          p,
    output logic signed [residual_width(K, MAX_DIGITS, DELTA)-1:0] w_next
);

    localparam int unsigned XY_W      = DIGIT_BITS * MAX_DIGITS;
    localparam int unsigned W_W       = residual_width(K, MAX_DIGITS, DELTA);
    localparam int unsigned PROD_W    = XY_W + DIGIT_BITS;
    localparam int unsigned W_FRAC    = K * (MAX_DIGITS + DELTA);
    localparam int unsigned SELM_SH   = K * SELM_FRAC_DIGITS;
    localparam int unsigned EST_LSB   = W_FRAC - SELM_SH;
    localparam int unsigned EST_W     = W_W - EST_LSB;
    localparam int          SELM_HALF = 1 << (SELM_SH - 1);
    localparam int          DIGIT_LIM = (1 << K) - 1;

    logic signed [PROD_W-1:0] prod_xy;
    logic signed [PROD_W-1:0] prod_yx;
    logic signed [W_W-1:0]    v;
    logic signed [EST_W-1:0]  est;
    logic signed [EST_W-1:0]  est_rnd;
    logic signed [EST_W-1:0]  p_sel;

    // The operand fractions carry K*DELTA fewer fractional bits than W, so the
    // raw products already sit at weight R^-DELTA in residual units.
    always_comb begin
        prod_xy = PROD_W'(x_prev) * PROD_W'(y_d);
        prod_yx = PROD_W'(y_cur) * PROD_W'(x_d);
        v       = (w <<< K) + W_W'(prod_xy) + W_W'(prod_yx);

        // Round-to-nearest on the truncated top of V, then clamp to the digit set.
        est     = v[W_W-1:EST_LSB];
        est_rnd = (est + EST_W'(SELM_HALF)) >>> SELM_SH;
        if (est_rnd > EST_W'(DIGIT_LIM)) begin
            p_sel = EST_W'(DIGIT_LIM);
        end else if (est_rnd < -EST_W'(DIGIT_LIM)) begin
            p_sel = -EST_W'(DIGIT_LIM);
        end else begin
            p_sel = est_rnd;
        end

        p      = force_zero ? '0 : DIGIT_BITS'(p_sel);
        w_next = v - (W_W'(p) <<< W_FRAC);
    end

endmodule

// File: rtl/online_multiplier_stream.sv
// MSD-first online multiplier for radix-2^K signed-digit operands with a
// start / valid-ready streaming interface.
//   clk, extern_reset        : clock, synchronous active-high reset
//   start, n_digits          : launch an operation of length n (clipped to MAX_DIGITS)
//   full_result_sel          : 0 -> n product digits, 1 -> 2n product digits
//   in_valid/in_ready        : operand digit pair handshake (x_digit, y_digit)
//   out_valid/out_ready      : product digit handshake (z_digit, z_last)
//   busy                     : operation in progress
module online_multiplier_stream
    import online_arith_pkg::*;
#(
    parameter int unsigned K          = 2,
    parameter int unsigned DIGIT_BITS = digit_width(K),
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned DELTA      = 2,
    parameter int unsigned CNT_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  extern_reset,
    input  logic                  start,
    input  logic [CNT_BITS-1:0]   n_digits,
    input  logic                  full_result_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGIT_BITS-1:0] x_digit,
    input  logic [DIGIT_BITS-1:0] y_digit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGIT_BITS-1:0] z_digit,
    output logic                  z_last,
    output logic                  busy
);

    localparam int unsigned XY_W    = DIGIT_BITS * MAX_DIGITS;
    localparam int unsigned XY_FRAC = K * MAX_DIGITS;
    localparam int unsigned W_W     = residual_width(K, MAX_DIGITS, DELTA);

    // Initial value of the "minus one ulp" converter register: -1.0.
    localparam logic [XY_W-1:0] QM_INIT = {{(XY_W - XY_FRAC){1'b1}}, {XY_FRAC{1'b0}}};

    omst_state_t state;
    omst_state_t state_nxt;

    logic [CNT_BITS-1:0]          j_cnt;
    logic [CNT_BITS-1:0]          n_eff;
    logic [CNT_BITS-1:0]          t_total;
    logic [CNT_BITS-1:0]          n_clip;
    logic [CNT_BITS-1:0]          t_calc;
    logic signed [XY_W-1:0]       x_q, x_qm, y_q, y_qm;
    logic signed [XY_W-1:0]       x_next, x_next_m, y_cur, y_next_m;
    logic signed [W_W-1:0]        w_q, w_next;
    logic signed [DIGIT_BITS-1:0] x_sat, y_sat, x_use, y_use, p;
    logic [K-1:0]                 x_dm1, y_dm1;
    int unsigned                  digit_sh;
    logic                         out_slot_free;
    logic                         start_ok;
    logic                         fire;
    logic                         emit;
    logic                         last_iter;

    // Handshake and iteration qualifiers.
    always_comb begin
        out_slot_free = !out_valid || out_ready;
        in_ready      = (state == ST_FEED) && out_slot_free;
        busy          = (state != ST_IDLE);
        start_ok      = (state == ST_IDLE) && start && (n_digits != '0);
        fire          = ((state == ST_FEED) && in_valid && in_ready) ||
                        ((state == ST_DRAIN) && out_slot_free);
        emit          = fire && (j_cnt >= CNT_BITS'(DELTA));
        last_iter     = (j_cnt == t_total - CNT_BITS'(1));
        n_clip        = (n_digits > CNT_BITS'(MAX_DIGITS)) ? CNT_BITS'(MAX_DIGITS) : n_digits;
        t_calc        = (full_result_sel ? (n_clip << 1) : n_clip) + CNT_BITS'(DELTA);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_ok) state_nxt = ST_FEED;
            ST_FEED:     if (fire && (j_cnt == n_eff - CNT_BITS'(1))) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (fire && last_iter) state_nxt = ST_LAST_OUT;
            ST_LAST_OUT: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (extern_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Input digit cleanup and on-the-fly conversion: the new digit is ORed into
    // its slot of either Q or QM, so no carry chain is needed.
    always_comb begin
        x_sat = DIGIT_BITS'(digit_saturate(DIGIT_MAX_W'($signed(x_digit)), K));
        y_sat = DIGIT_BITS'(digit_saturate(DIGIT_MAX_W'($signed(y_digit)), K));
        x_use = '0;
        y_use = '0;
        if (state == ST_FEED) begin
            x_use = x_sat;
            y_use = y_sat;
        end

        digit_sh = 0;
        if (32'(j_cnt) < MAX_DIGITS) begin
            digit_sh = K * (MAX_DIGITS - 1 - 32'(j_cnt));
        end

        x_dm1    = x_use[K-1:0] - K'(1);
        y_dm1    = y_use[K-1:0] - K'(1);
        x_next   = ((x_use >= 0) ? x_q : x_qm) | (XY_W'(x_use[K-1:0]) << digit_sh);
        x_next_m = ((x_use > 0)  ? x_q : x_qm) | (XY_W'(x_dm1) << digit_sh);
        y_cur    = ((y_use >= 0) ? y_q : y_qm) | (XY_W'(y_use[K-1:0]) << digit_sh);
        y_next_m = ((y_use > 0)  ? y_q : y_qm) | (XY_W'(y_dm1) << digit_sh);
    end

    online_mult_step #(
        .K          (K),
        .DIGIT_BITS (DIGIT_BITS),
        .MAX_DIGITS (MAX_DIGITS),
        .DELTA      (DELTA)
    ) u_step (
        .x_prev     (x_q),
        .y_cur      (y_cur),
        .x_d        (x_use),
        .y_d        (y_use),
        .w          (w_q),
        .force_zero (j_cnt < CNT_BITS'(DELTA)),
        .p          (p),
        .w_next     (w_next)
    );

    // Counters, converters, residual and output register.
    always_ff @(posedge clk) begin
        if (extern_reset) begin
            j_cnt     <= '0;
            n_eff     <= '0;
            t_total   <= '0;
            x_q       <= '0;
            x_qm      <= '0;
            y_q       <= '0;
            y_qm      <= '0;
            w_q       <= '0;
            z_digit   <= '0;
            out_valid <= 1'b0;
            z_last    <= 1'b0;
        end else begin
            if (start_ok) begin
                n_eff   <= n_clip;
                t_total <= t_calc;
                j_cnt   <= '0;
                w_q     <= '0;
                x_q     <= '0;
                x_qm    <= QM_INIT;
                y_q     <= '0;
                y_qm    <= QM_INIT;
            end
            if (fire) begin
                j_cnt <= j_cnt + CNT_BITS'(1);
                w_q   <= w_next;
                if (state == ST_FEED) begin
                    x_q  <= x_next;
                    x_qm <= x_next_m;
                    y_q  <= y_cur;
                    y_qm <= y_next_m;
                end
            end
            if (emit) begin
                z_digit   <= p;
                out_valid <= 1'b1;
                z_last    <= last_iter;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                z_last    <= 1'b0;
            end
        end
    end

endmodule
